// File: rtl/clk_en_gen.sv
// clk_en_gen: holds the design in reset until PLL lock is stable, then emits phase-aligned clock enables.
// Optional feature macro CLK_EN_GEN_LOSS_EN: lock loss in RUN returns to reset and sets sticky lock_lost.
module clk_en_gen #(
  parameter int                     CHANNELS    = 2,
  parameter logic [16*CHANNELS-1:0] DIVS        = {16'd2, 16'd16},
  parameter int                     LOCK_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lock,
  output logic                rst_out,
  output logic                ready,
  output logic [CHANNELS-1:0] ce,
  output logic                lock_lost
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_CYCLES - 1);

  // Illegal configurations reference a module that does not exist, so elaboration stops.
  if (CHANNELS < 1 || CHANNELS > 8 || LOCK_CYCLES < 1) begin : g_bad_cfg
    unsupported_clk_en_config u_unsupported ();
  end else begin : g_div_chk
    for (genvar g = 0; g < CHANNELS; g++) begin : g_div
      if (DIVS[16*g +: 16] == 16'd0) begin : g_bad_div
        unsupported_clk_en_config u_unsupported ();
      end
    end
  end

  typedef enum logic [1:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sync1_q, lock_s_q;
  logic                rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic [15:0]         dcnt_q [CHANNELS];
  logic [15:0]         dcnt_d [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      ce_q      <= '0;
      for (int i = 0; i < CHANNELS; i++) dcnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= lock;
      lock_s_q  <= sync1_q;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      ce_q      <= ce_d;
      for (int i = 0; i < CHANNELS; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Any synchronised low while counting restarts the whole stability window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RESET: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
`ifdef CLK_EN_GEN_LOSS_EN
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
`endif
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_comb begin
    rst_out_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    ce_d      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      dcnt_d[i] = '0;
      if (state_q == S_RUN && state_d == S_RUN) begin
        if (dcnt_q[i] == DIVS[16*i +: 16] - 16'd1) dcnt_d[i] = '0;
        else dcnt_d[i] = dcnt_q[i] + 16'd1;
      end
      ce_d[i] = (state_d == S_RUN) && (dcnt_d[i] == DIVS[16*i +: 16] - 16'd1);
    end
  end

`ifdef CLK_EN_GEN_LOSS_EN
  logic lock_lost_q;

  always_ff @(posedge clk) begin
    if (rst) lock_lost_q <= 1'b0;
    else if (state_q == S_RUN && !lock_s_q) lock_lost_q <= 1'b1;
  end

  assign lock_lost = lock_lost_q;
`else
  assign lock_lost = 1'b0;
`endif

  assign rst_out = rst_out_q;
  assign ready   = ready_q;
  assign ce      = ce_q;

endmodule
